// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit seven-segment scan controller.
// Cycles the digit select through 0..7 with a blanking gap before each digit.
// Host writes land in a staging register and are committed to the display
// value only at the frame boundary, so one frame never mixes two values.
module seg_scan_ctrl #(
    parameter int unsigned ON_CYC    = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_lz_en,
    input  logic        i_ld_req,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ack,
    output logic        o_pending,
    output logic [2:0]  o_sel,
    output logic [31:0] o_shadow,
    output logic [7:0]  o_an,
    output logic        o_frame_tick
);

    localparam int unsigned MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

    typedef enum logic {StBlank, StOn} state_t;

    state_t      r_state, w_state_nxt;
    logic [TW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_sel, w_sel_nxt;
    logic [7:0]  r_an, w_an_nxt;
    logic [31:0] r_shadow, w_shadow_nxt;
    logic [31:0] r_staging, w_staging_nxt;
    logic        r_pending, w_pending_nxt;
    logic        r_ld_ack;
    logic        r_frame_tick;
    logic        w_boundary;
    logic        w_lz_blank;

    // Digit is blanked when every nibble from the current digit upwards is zero.
    assign w_lz_blank = i_lz_en && (r_sel != 3'd0) &&
                        ((r_shadow >> {r_sel, 2'b00}) == 32'd0);

    // Scan FSM next state, slot timer, digit select and anode pattern.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_an_nxt    = r_an;
        w_boundary  = 1'b0;
        if (!i_enable) begin
            // Park in BLANK so re-enable always starts with a full gap.
            w_state_nxt = StBlank;
            w_cnt_nxt   = '0;
            w_an_nxt    = 8'hFF;
        end else begin
            unique case (r_state)
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = StOn;
                        w_cnt_nxt   = '0;
                        w_an_nxt    = w_lz_blank ? 8'hFF : ~(8'h01 << r_sel);
                    end else begin
                        w_cnt_nxt = r_cnt + TW'(1);
                    end
                end
                StOn: begin
                    if (r_cnt == ON_LAST) begin
                        w_state_nxt = StBlank;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = r_sel + 3'd1;
                        w_an_nxt    = 8'hFF;
                        w_boundary  = (r_sel == 3'd7);
                    end else begin
                        w_cnt_nxt = r_cnt + TW'(1);
                    end
                end
                default: begin
                    w_state_nxt = StBlank;
                    w_cnt_nxt   = '0;
                    w_an_nxt    = 8'hFF;
                end
            endcase
        end
    end

    // Staging and commit; a write in the boundary cycle goes straight to shadow.
    always_comb begin
        w_staging_nxt = r_staging;
        w_pending_nxt = r_pending;
        w_shadow_nxt  = r_shadow;
        if (i_ld_req) begin
            w_staging_nxt = i_ld_data;
            w_pending_nxt = 1'b1;
        end
        if (w_boundary) begin
            if (i_ld_req) begin
                w_shadow_nxt = i_ld_data;
            end else if (r_pending) begin
                w_shadow_nxt = r_staging;
            end
            w_pending_nxt = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StBlank;
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_an         <= 8'hFF;
            r_shadow     <= 32'd0;
            r_staging    <= 32'd0;
            r_pending    <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_an         <= w_an_nxt;
            r_shadow     <= w_shadow_nxt;
            r_staging    <= w_staging_nxt;
            r_pending    <= w_pending_nxt;
            r_ld_ack     <= i_ld_req;
            r_frame_tick <= w_boundary;
        end
    end

    assign o_ld_ack     = r_ld_ack;
    assign o_pending    = r_pending;
    assign o_sel        = r_sel;
    assign o_shadow     = r_shadow;
    assign o_an         = r_an;
    assign o_frame_tick = r_frame_tick;

endmodule
